// File: rtl/prog_inst_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_inst_mem_if
// Purpose  : Bundles the load stream and the fetch port of prog_inst_mem.
//            The loader/core side uses the master modport and the memory
//            uses the slave modport.
// Signals  : LoadStart/LoadValid/LoadData/LoadLast -> memory (load stream)
//            LoadReady/MemReady/LoadFull/LoadCount -> loader (load status)
//            FetchReq/InstAddress                  -> memory (fetch request)
//            InstOut/InstValid                     -> core   (fetch result)
// Revision : 1.0  initial release
// ============================================================================
interface prog_inst_mem_if #(
  parameter int A = 10,
  parameter int W = 9
);
  logic         LoadStart;
  logic         LoadValid;
  logic [W-1:0] LoadData;
  logic         LoadLast;
  logic         LoadReady;
  logic         MemReady;
  logic         LoadFull;
  logic [A:0]   LoadCount;
  logic         FetchReq;
  logic [A-1:0] InstAddress;
  logic [W-1:0] InstOut;
  logic         InstValid;

  modport master (
    output LoadStart, LoadValid, LoadData, LoadLast, FetchReq, InstAddress,
    input  LoadReady, MemReady, LoadFull, LoadCount, InstOut, InstValid
  );

  modport slave (
    input  LoadStart, LoadValid, LoadData, LoadLast, FetchReq, InstAddress,
    output LoadReady, MemReady, LoadFull, LoadCount, InstOut, InstValid
  );
endinterface
`default_nettype wire

// File: rtl/prog_inst_mem.sv
`default_nettype none
// ============================================================================
// Module   : prog_inst_mem
// Purpose  : Run-time loadable instruction memory. A program is streamed in
//            over a valid/ready port, then read through a registered fetch
//            port with one cycle of latency. Fetches at or beyond the loaded
//            program length return the FILL word.
// Ports    : Clk    - clock, all state changes on the rising edge
//            Reset  - asynchronous, active-high reset
//            bus    - prog_inst_mem_if.slave (load stream, status, fetch)
// Params   : A    - address bits (depth 2**A words)
//            W    - instruction width
//            FILL - word returned for addresses >= LoadCount
// Revision : 1.0  initial release
// ============================================================================
module prog_inst_mem #(
  parameter int           A    = 10,
  parameter int           W    = 9,
  parameter logic [W-1:0] FILL = {W{1'b1}}
) (
  input  logic             Clk,
  input  logic             Reset,
  prog_inst_mem_if.slave   bus
);

  localparam int DEPTH = 2 ** A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;

  logic [W-1:0] mem [DEPTH];

  logic [A-1:0] ptr;
  logic [A:0]   load_count;
  logic         load_full;
  logic [W-1:0] inst_out;
  logic         inst_valid;

  logic         load_ready;
  logic         mem_ready;
  logic         restart;
  logic         beat_acc;
  logic         fetch_acc;
  logic         last_slot;
  logic         in_range;

  // The pointer saturates on the final slot instead of wrapping, so the
  // last accepted beat is recognised by the pointer being all ones.
  assign last_slot = &ptr;

  // Unsigned compare at A+1 bits so a full memory (LoadCount = 2**A)
  // makes every address valid.
  assign in_range = ({1'b0, bus.InstAddress} < load_count);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and per-cycle control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    mem_ready  = 1'b0;
    restart    = 1'b0;
    beat_acc   = 1'b0;
    fetch_acc  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.LoadStart) begin
          restart    = 1'b1;
          next_state = LOADING;
        end
      end

      LOADING: begin
        load_ready = 1'b1;
        // A restart wins over a beat presented in the same cycle; the
        // beat is discarded rather than written at the old pointer.
        if (bus.LoadStart) begin
          restart = 1'b1;
        end else if (bus.LoadValid) begin
          beat_acc = 1'b1;
          if (bus.LoadLast || last_slot) begin
            next_state = READY;
          end
        end
      end

      READY: begin
        mem_ready = 1'b1;
        // A fetch coinciding with a reload is dropped: the program it
        // would read from is being replaced.
        if (bus.LoadStart) begin
          restart    = 1'b1;
          next_state = LOADING;
        end else begin
          fetch_acc = bus.FetchReq;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage array: written only while loading, never reset
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (beat_acc) begin
      mem[ptr] <= bus.LoadData;
    end
  end

  // --------------------------------------------------------------------------
  // Load bookkeeping and registered fetch port
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr        <= '0;
      load_count <= '0;
      load_full  <= 1'b0;
      inst_out   <= '0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= fetch_acc;
      if (fetch_acc) begin
        inst_out <= in_range ? mem[bus.InstAddress] : FILL;
      end

      if (restart) begin
        ptr        <= '0;
        load_count <= '0;
        load_full  <= 1'b0;
      end else if (beat_acc) begin
        load_count <= load_count + {{A{1'b0}}, 1'b1};
        if (!last_slot) begin
          ptr <= ptr + {{(A-1){1'b0}}, 1'b1};
        end else if (!bus.LoadLast) begin
          // Memory filled without the loader marking the end.
          load_full <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.LoadReady = load_ready;
  assign bus.MemReady  = mem_ready;
  assign bus.LoadFull  = load_full;
  assign bus.LoadCount = load_count;
  assign bus.InstOut   = inst_out;
  assign bus.InstValid = inst_valid;

endmodule
`default_nettype wire

// File: tb/tb_prog_inst_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_inst_mem
// Purpose  : Self-checking bench for prog_inst_mem. Two instances: A=10 for
//            the general program/fetch behaviour and A=3 for the full-depth
//            cases. Expected fetch results come from the list of words the
//            bench loaded, and are queued with the cycle they are due in;
//            a negedge monitor pops and compares them.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_inst_mem;

  localparam logic [8:0] FILL = 9'h1FF;

  typedef struct {
    int         due;
    logic [8:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] prog1[$];
  logic [8:0] prog2[$];
  exp_t       q1[$];
  exp_t       q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_inst_mem_if #(.A(10), .W(9)) b1();
  prog_inst_mem_if #(.A(3),  .W(9)) b2();

  prog_inst_mem #(.A(10), .W(9), .FILL(FILL)) dut1 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (b1)
  );

  prog_inst_mem #(.A(3), .W(9), .FILL(FILL)) dut2 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (b2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: a loaded program is just the ordered list of accepted words.
  function automatic logic [8:0] exp1(input int addr);
    return (addr < prog1.size()) ? prog1[addr] : FILL;
  endfunction

  function automatic logic [8:0] exp2(input int addr);
    return (addr < prog2.size()) ? prog2[addr] : FILL;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result is due after the edge that samples this request.
  task automatic fetch1(input int addr);
    b1.FetchReq    = 1'b1;
    b1.InstAddress = addr[9:0];
    q1.push_back('{cyc + 1, exp1(addr)});
    tick();
  endtask

  task automatic fetch2(input int addr);
    b2.FetchReq    = 1'b1;
    b2.InstAddress = addr[2:0];
    q2.push_back('{cyc + 1, exp2(addr)});
    tick();
  endtask

  task automatic start1();
    b1.LoadStart = 1'b1;
    tick();
    b1.LoadStart = 1'b0;
    prog1.delete();
  endtask

  task automatic start2();
    b2.LoadStart = 1'b1;
    tick();
    b2.LoadStart = 1'b0;
    prog2.delete();
  endtask

  // Stream words with random idle gaps; LoadLast toggles randomly while
  // LoadValid is low and must be ignored then.
  task automatic beats1(input logic [8:0] w[$], input bit mark_last);
    for (int i = 0; i < w.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        b1.LoadValid = 1'b0;
        b1.LoadData  = 9'($urandom);
        b1.LoadLast  = 1'($urandom);
        tick();
      end
      b1.LoadValid = 1'b1;
      b1.LoadData  = w[i];
      b1.LoadLast  = mark_last && (i == w.size() - 1);
      tick();
      prog1.push_back(w[i]);
    end
    b1.LoadValid = 1'b0;
    b1.LoadLast  = 1'b0;
  endtask

  // Monitor: a result due this cycle must be present with the right data;
  // any other valid is spurious.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        check("dut1_valid", {31'd0, b1.InstValid}, 32'd1);
        check("dut1_inst", {23'd0, b1.InstOut}, {23'd0, e.data});
      end else if (b1.InstValid !== 1'b0) begin
        check("dut1_spurious_valid", {31'd0, b1.InstValid}, 32'd0);
      end
      if (q2.size() > 0 && q2[0].due <= cyc) begin
        e = q2.pop_front();
        check("dut2_valid", {31'd0, b2.InstValid}, 32'd1);
        check("dut2_inst", {23'd0, b2.InstOut}, {23'd0, e.data});
      end else if (b2.InstValid !== 1'b0) begin
        check("dut2_spurious_valid", {31'd0, b2.InstValid}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [8:0] w[$];
    int n;

    rst = 1'b1;
    b1.LoadStart = 0; b1.LoadValid = 0; b1.LoadData = 0; b1.LoadLast = 0;
    b1.FetchReq = 0;  b1.InstAddress = 0;
    b2.LoadStart = 0; b2.LoadValid = 0; b2.LoadData = 0; b2.LoadLast = 0;
    b2.FetchReq = 0;  b2.InstAddress = 0;
    repeat (3) tick();

    // Reset values
    check("rst_load_ready", {31'd0, b1.LoadReady}, 0);
    check("rst_mem_ready",  {31'd0, b1.MemReady}, 0);
    check("rst_load_full",  {31'd0, b1.LoadFull}, 0);
    check("rst_load_count", {21'd0, b1.LoadCount}, 0);
    check("rst_inst_out",   {23'd0, b1.InstOut}, 0);
    check("rst_inst_valid", {31'd0, b1.InstValid}, 0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // IDLE ignores beats and fetches
    b1.FetchReq = 1; b1.LoadValid = 1; b1.LoadData = 9'h055;
    tick();
    b1.FetchReq = 0; b1.LoadValid = 0;
    check("idle_inst_valid", {31'd0, b1.InstValid}, 0);
    check("idle_load_count", {21'd0, b1.LoadCount}, 0);
    check("idle_mem_ready",  {31'd0, b1.MemReady}, 0);

    // Five-word program 001..005
    start1();
    check("loading_ready", {31'd0, b1.LoadReady}, 1);
    w.delete();
    for (int i = 1; i <= 5; i++) w.push_back(9'(i));
    beats1(w, 1'b1);
    check("p5_mem_ready",  {31'd0, b1.MemReady}, 1);
    check("p5_load_ready", {31'd0, b1.LoadReady}, 0);
    check("p5_load_count", {21'd0, b1.LoadCount}, 5);
    check("p5_load_full",  {31'd0, b1.LoadFull}, 0);
    for (int a = 0; a < 5; a++) fetch1(a);
    fetch1(5);
    fetch1(1023);
    b1.FetchReq = 0;
    tick();
    check("hold_inst_valid", {31'd0, b1.InstValid}, 0);
    check("hold_inst_out",   {23'd0, b1.InstOut}, {23'd0, FILL});

    // Random fetch traffic on the five-word program
    repeat (40) begin
      if ($urandom_range(0, 1) == 1) begin
        fetch1(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 9)));
      end else begin
        b1.FetchReq    = 1'b0;
        b1.InstAddress = 10'($urandom);
        tick();
      end
    end
    b1.FetchReq = 0;

    // Restart mid-load: the coincident beat is discarded
    start1();
    w.delete();
    repeat (3) w.push_back(9'($urandom));
    beats1(w, 1'b0);
    b1.LoadStart = 1; b1.LoadValid = 1; b1.LoadData = 9'h077;
    tick();
    b1.LoadStart = 0; b1.LoadValid = 0;
    prog1.delete();
    check("restart_count", {21'd0, b1.LoadCount}, 0);
    check("restart_ready", {31'd0, b1.LoadReady}, 1);
    w.delete();
    w.push_back(9'h0AA);
    w.push_back(9'h0BB);
    beats1(w, 1'b1);
    check("ab_load_count", {21'd0, b1.LoadCount}, 2);
    fetch1(0);
    fetch1(1);
    fetch1(2);
    b1.FetchReq = 0;
    tick();

    // Random program, random fetches
    start1();
    n = $urandom_range(1, 40);
    w.delete();
    repeat (n) w.push_back(9'($urandom));
    beats1(w, 1'b1);
    check("rand_load_count", {21'd0, b1.LoadCount}, n);
    repeat (60) begin
      if ($urandom_range(0, 3) != 0) begin
        fetch1(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 63)));
      end else begin
        b1.FetchReq = 1'b0;
        tick();
      end
    end
    b1.FetchReq = 0;
    tick();

    // Fetch together with LoadStart in READY: fetch dropped
    b1.FetchReq = 1; b1.InstAddress = 0; b1.LoadStart = 1;
    tick();
    b1.FetchReq = 0; b1.LoadStart = 0;
    prog1.delete();
    check("drop_inst_valid", {31'd0, b1.InstValid}, 0);
    check("drop_mem_ready",  {31'd0, b1.MemReady}, 0);
    check("drop_load_ready", {31'd0, b1.LoadReady}, 1);
    check("drop_load_count", {21'd0, b1.LoadCount}, 0);
    w.delete();
    repeat (3) w.push_back(9'($urandom));
    beats1(w, 1'b1);
    for (int a = 0; a < 4; a++) fetch1(a);
    fetch1(900);
    b1.FetchReq = 0;
    tick();

    // Asynchronous reset between edges during LOADING
    start1();
    w.delete();
    repeat (2) w.push_back(9'($urandom));
    beats1(w, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_load_ready", {31'd0, b1.LoadReady}, 0);
    check("async_load_count", {21'd0, b1.LoadCount}, 0);
    check("async_inst_out",   {23'd0, b1.InstOut}, 0);
    check("async_mem_ready",  {31'd0, b1.MemReady}, 0);
    check("async_inst_valid", {31'd0, b1.InstValid}, 0);
    tick();
    rst = 1'b0;
    b1.FetchReq = 1; b1.InstAddress = 0;
    tick();
    b1.FetchReq = 0;
    check("post_rst_valid", {31'd0, b1.InstValid}, 0);
    check("post_rst_ready", {31'd0, b1.LoadReady}, 0);

    // A=3: eight beats without LoadLast fill the memory
    start2();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        b2.LoadValid = 0;
        tick();
      end
      b2.LoadValid = 1; b2.LoadData = 9'(9'h010 + i); b2.LoadLast = 0;
      tick();
      prog2.push_back(9'(9'h010 + i));
    end
    b2.LoadValid = 0;
    check("full_load_full",  {31'd0, b2.LoadFull}, 1);
    check("full_load_count", {27'd0, b2.LoadCount}, 8);
    check("full_mem_ready",  {31'd0, b2.MemReady}, 1);
    fetch2(7);
    for (int a = 0; a < 8; a++) fetch2(a);
    b2.FetchReq = 0;
    b2.LoadValid = 1; b2.LoadData = 9'h1AB;
    tick();
    b2.LoadValid = 0;
    check("ready_ignores_beat", {27'd0, b2.LoadCount}, 8);

    // A=3: LoadLast on the final slot ends normally, LoadFull clear
    start2();
    check("restart_clears_full", {31'd0, b2.LoadFull}, 0);
    for (int i = 0; i < 8; i++) begin
      b2.LoadValid = 1; b2.LoadData = 9'($urandom); b2.LoadLast = (i == 7);
      prog2.push_back(b2.LoadData);
      tick();
    end
    b2.LoadValid = 0; b2.LoadLast = 0;
    check("last_load_full",  {31'd0, b2.LoadFull}, 0);
    check("last_load_count", {27'd0, b2.LoadCount}, 8);
    check("last_mem_ready",  {31'd0, b2.MemReady}, 1);
    for (int a = 7; a >= 0; a--) fetch2(a);
    b2.FetchReq = 0;

    // Drain outstanding results with a bounded wait
    for (int k = 0; k < 5 && (q1.size() > 0 || q2.size() > 0); k++) tick();
    check("drain_q1", q1.size(), 0);
    check("drain_q2", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
